// File: rtl/conv_strip_feeder.sv
// conv_strip_feeder: buffers a sliding 3-row band of a raster frame and replays it column-wise to the conv controller.
// Defining CONV_FEEDER_STALL_EN adds stall_i, which pauses emission while high.
module conv_strip_feeder #(
   parameter int PIXEL_WIDTH = 8,
   parameter int IMG_WIDTH = 16,
   parameter int IMG_HEIGHT = 16
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic frame_start_i,
   input  logic px_valid_i,
   input  logic [PIXEL_WIDTH-1:0] px_i,
`ifdef CONV_FEEDER_STALL_EN
   input  logic stall_i,
`endif
   output logic px_ready_o,
   output logic start_cnn_o,
   output logic px_rdy_o,
   output logic [PIXEL_WIDTH-1:0] px_o,
   output logic frame_done_o
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int KW = $clog2(3 * IMG_WIDTH);
   localparam int SW = $clog2(IMG_HEIGHT);
   typedef enum logic [1:0] {IDLE, FILL, EMIT, GAP} state_t;
   state_t state;
   logic [PIXEL_WIDTH-1:0] mem [3][IMG_WIDTH];
   logic [1:0] wr_row, top, need_rows, er, rd_row;
   logic [2:0] rs;
   logic [CW-1:0] col;
   logic [KW-1:0] k;
   logic [SW-1:0] strip;
   logic ph, gap_n, stall, take, last_col;
`ifdef CONV_FEEDER_STALL_EN
   assign stall = stall_i;
`else
   assign stall = 1'b0;
`endif
   always_comb begin
      take = px_valid_i && px_ready_o;
      last_col = col == CW'(IMG_WIDTH - 1);
      rs = {1'b0, top} + {1'b0, er};
      rd_row = rs >= 3'd3 ? 2'(rs - 3'd3) : rs[1:0];
   end
   always_ff @(posedge clk_i)
      if (take) mem[wr_row][col] <= px_i;
   // ph=0 schedules a pulse for the next cycle, ph=1 is the visible pulse cycle
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state <= IDLE;
         px_ready_o <= 1'b0;
         start_cnn_o <= 1'b0;
         px_rdy_o <= 1'b0;
         px_o <= '0;
         frame_done_o <= 1'b0;
         wr_row <= 2'd0;
         top <= 2'd0;
         need_rows <= 2'd0;
         er <= 2'd0;
         col <= '0;
         k <= '0;
         strip <= '0;
         ph <= 1'b0;
         gap_n <= 1'b0;
      end else begin
         case (state)
            IDLE: if (frame_start_i) begin
               state <= FILL;
               px_ready_o <= 1'b1;
               wr_row <= 2'd0;
               top <= 2'd0;
               col <= '0;
               strip <= '0;
               need_rows <= 2'd3;
            end
            FILL: if (take) begin
               col <= last_col ? '0 : col + 1'b1;
               if (last_col) begin
                  wr_row <= wr_row == 2'd2 ? 2'd0 : wr_row + 2'd1;
                  need_rows <= need_rows - 2'd1;
                  if (need_rows == 2'd1) begin
                     state <= EMIT;
                     px_ready_o <= 1'b0;
                     start_cnn_o <= 1'b1;
                     ph <= 1'b0;
                     er <= 2'd0;
                     k <= '0;
                  end
               end
            end
            EMIT: if (stall) begin
               px_rdy_o <= 1'b0;
            end else if (!ph) begin
               ph <= 1'b1;
               px_rdy_o <= 1'b1;
               px_o <= mem[rd_row][col];
            end else begin
               ph <= 1'b0;
               px_rdy_o <= 1'b0;
               if (k == KW'(3 * IMG_WIDTH - 1)) begin
                  state <= GAP;
                  start_cnn_o <= 1'b0;
                  px_o <= '0;
                  gap_n <= 1'b0;
                  col <= '0;
               end else begin
                  k <= k + 1'b1;
                  er <= er == 2'd2 ? 2'd0 : er + 2'd1;
                  col <= er == 2'd2 ? col + 1'b1 : col;
               end
            end
            GAP: if (!gap_n) begin
               gap_n <= 1'b1;
               top <= top == 2'd2 ? 2'd0 : top + 2'd1;
               strip <= strip + 1'b1;
               frame_done_o <= strip == SW'(IMG_HEIGHT - 3);
            end else begin
               frame_done_o <= 1'b0;
               if (strip == SW'(IMG_HEIGHT - 2)) begin
                  state <= IDLE;
               end else begin
                  state <= FILL;
                  px_ready_o <= 1'b1;
                  need_rows <= 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_strip_feeder.sv
// tb_conv_strip_feeder: scoreboard bench for conv_strip_feeder with a 4x5 frame and a queue-based reference model.
module tb_conv_strip_feeder;
   localparam int W = 4;
   localparam int H = 5;
   localparam int N = W * H;
   localparam int PULSES = 3 * W;
   logic clk = 1'b0;
   logic reset_i = 1'b1;
   logic frame_start_i = 1'b0;
   logic px_valid_i = 1'b0;
   logic [7:0] px_i = 8'd0;
   logic stall_i = 1'b0;
   logic px_ready_o, start_cnn_o, px_rdy_o, frame_done_o;
   logic [7:0] px_o;
   int tests = 0, fails = 0, cyc = 0, fd_cnt = 0;
   int rise_cyc = 0, last_pulse = 0, pulses = 0, strips_seen = 0, fall_cyc = -100;
   bit prev_start = 0, prev_ready = 0, prev_rdy = 0, stall_mode = 0;
   logic [7:0] img [N];
   logic [7:0] exp_q [$];

   conv_strip_feeder #(.PIXEL_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk_i(clk),
      .reset_i(reset_i),
      .frame_start_i(frame_start_i),
      .px_valid_i(px_valid_i),
      .px_i(px_i),
`ifdef CONV_FEEDER_STALL_EN
      .stall_i(stall_i),
`endif
      .px_ready_o(px_ready_o),
      .start_cnn_o(start_cnn_o),
      .px_rdy_o(px_rdy_o),
      .px_o(px_o),
      .frame_done_o(frame_done_o)
   );

   always #5 clk = ~clk;

   // monitor: pops the scoreboard on every pulse and checks strip framing
   always @(negedge clk) begin
      logic [7:0] e;
      int want;
      cyc++;
      if (start_cnn_o === 1'b1 && !prev_start) begin
         tests++;
         if (!(prev_ready && px_ready_o === 1'b0 && px_rdy_o === 1'b0)) begin
            fails++;
            $display("FAIL emit_entry cyc=%0d prev_ready=%0b ready=%b rdy=%b want 1,0,0", cyc, prev_ready, px_ready_o, px_rdy_o);
         end
         rise_cyc = cyc;
         pulses = 0;
      end
      if (px_rdy_o === 1'b1) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL px_value cyc=%0d got %0d want no pulse", cyc, px_o);
         end else begin
            e = exp_q.pop_front();
            if (px_o !== e) begin
               fails++;
               $display("FAIL px_value cyc=%0d got %0d want %0d", cyc, px_o, e);
            end
         end
         tests++;
         want = pulses == 0 ? 1 : 2;
         if (start_cnn_o !== 1'b1 || (!stall_mode && cyc - (pulses == 0 ? rise_cyc : last_pulse) != want)) begin
            fails++;
            $display("FAIL px_cadence cyc=%0d spacing=%0d want %0d start=%b", cyc, cyc - (pulses == 0 ? rise_cyc : last_pulse), want, start_cnn_o);
         end
         pulses++;
         last_pulse = cyc;
      end
      if (start_cnn_o === 1'b0 && prev_start) begin
         strips_seen++;
         fall_cyc = cyc;
         tests++;
         if (pulses != PULSES || !prev_rdy || px_ready_o !== 1'b0 || px_rdy_o !== 1'b0) begin
            fails++;
            $display("FAIL strip_end cyc=%0d pulses=%0d want %0d last_rdy=%0b ready=%b", cyc, pulses, PULSES, prev_rdy, px_ready_o);
         end
      end
      if (cyc == fall_cyc + 1) begin
         tests++;
         if (frame_done_o !== (strips_seen == H - 2) || px_ready_o !== 1'b0 || start_cnn_o !== 1'b0) begin
            fails++;
            $display("FAIL gap_cycle2 cyc=%0d done=%b want %0b ready=%b start=%b", cyc, frame_done_o, strips_seen == H - 2, px_ready_o, start_cnn_o);
         end
      end else if (frame_done_o === 1'b1) begin
         tests++;
         fails++;
         $display("FAIL stray_frame_done cyc=%0d got 1 want 0", cyc);
      end
      if (frame_done_o === 1'b1) fd_cnt++;
      if (cyc == fall_cyc + 2) begin
         tests++;
         if (px_ready_o !== (strips_seen < H - 2) || start_cnn_o !== 1'b0) begin
            fails++;
            $display("FAIL gap_exit cyc=%0d ready=%b want %0b start=%b", cyc, px_ready_o, strips_seen < H - 2, start_cnn_o);
         end
         if (strips_seen == H - 2) strips_seen = 0;
      end
      prev_start = start_cnn_o === 1'b1;
      prev_ready = px_ready_o === 1'b1;
      prev_rdy = px_rdy_o === 1'b1;
      if (reset_i === 1'b1) begin
         exp_q.delete();
         prev_start = 0;
         prev_ready = 0;
         prev_rdy = 0;
         strips_seen = 0;
         fall_cyc = -100;
         pulses = 0;
      end
   end

   task automatic load_image(input bit raster);
      for (int i = 0; i < N; i++) img[i] = raster ? 8'(i) : 8'($urandom);
   endtask

   task automatic check_outputs_zero(input string name);
      tests++;
      if ({px_ready_o, start_cnn_o, px_rdy_o, frame_done_o} !== 4'b0 || px_o !== 8'd0) begin
         fails++;
         $display("FAIL %s ready=%b start=%b rdy=%b done=%b px=%0d want all 0", name, px_ready_o, start_cnn_o, px_rdy_o, frame_done_o, px_o);
      end
   endtask

   task automatic run_frame(input bit gaps, input bit junk, input int reset_at, input bit do_stall);
      int idx = 0, pc = 0, dc = 0, p3 = 0, sc = 0, budget = 0;
      int fd0 = fd_cnt;
      bit v;
      for (int s = 0; s < H - 2; s++)
         for (int c = 0; c < W; c++)
            for (int r = 0; r < 3; r++) exp_q.push_back(img[(s + r) * W + c]);
      stall_mode = do_stall;
      @(posedge clk); #1;
      frame_start_i = 1'b1;
      @(posedge clk); #1;
      frame_start_i = 1'b0;
      tests++;
      if (px_ready_o !== 1'b1) begin
         fails++;
         $display("FAIL fill_entry ready=%b want 1", px_ready_o);
      end
      while (fd_cnt == fd0 && budget < 3000) begin
         if (do_stall) begin
            stall_i = sc > 0;
            if (sc > 0) begin
               sc--;
               tests++;
               if (start_cnn_o !== 1'b1 || px_rdy_o !== 1'b0) begin
                  fails++;
                  $display("FAIL stall_hold start=%b rdy=%b want 1,0", start_cnn_o, px_rdy_o);
               end
            end
         end
         if (px_rdy_o === 1'b1) begin
            pc++;
            if (do_stall && pc == 3) begin
               sc = 5;
               p3 = dc;
            end
            if (do_stall && pc == 4) begin
               tests++;
               if (dc - p3 != 7 || px_o !== img[1]) begin
                  fails++;
                  $display("FAIL stall_resume delay=%0d want 7 px=%0d want %0d", dc - p3, px_o, img[1]);
               end
            end
            if (pc == reset_at) begin
               reset_i = 1'b1;
               px_valid_i = 1'b0;
               frame_start_i = 1'b0;
               @(posedge clk); #1;
               reset_i = 1'b0;
               check_outputs_zero("reset_mid");
               repeat (3) @(posedge clk);
               #1;
               check_outputs_zero("idle_after_reset");
               return;
            end
         end
         if (px_ready_o === 1'b1) begin
            frame_start_i = 1'b0;
            v = gaps ? $urandom_range(0, 2) != 0 : 1'b1;
            px_valid_i = v && idx < N;
            px_i = idx < N ? img[idx] : 8'd0;
            if (v && idx < N) idx++;
         end else begin
            px_valid_i = junk && $urandom_range(0, 1) == 1;
            px_i = 8'($urandom);
            frame_start_i = junk && start_cnn_o === 1'b1 && $urandom_range(0, 3) == 0;
         end
         @(posedge clk); #1;
         budget++;
         dc++;
      end
      px_valid_i = 1'b0;
      frame_start_i = 1'b0;
      stall_i = 1'b0;
      if (budget >= 3000) begin
         tests++;
         fails++;
         $display("FAIL frame_timeout budget=%0d want frame_done", budget);
      end
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (fd_cnt != fd0 + 1 || exp_q.size() != 0 || px_ready_o !== 1'b0 || start_cnn_o !== 1'b0) begin
         fails++;
         $display("FAIL frame_end done_pulses=%0d want 1 leftover=%0d want 0 ready=%b start=%b", fd_cnt - fd0, exp_q.size(), px_ready_o, start_cnn_o);
      end
      stall_mode = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset_values");
      reset_i = 1'b0;
      load_image(1);
      run_frame(0, 0, 0, 0);
      run_frame(0, 1, 0, 0);
      run_frame(1, 0, 0, 0);
      run_frame(0, 0, PULSES + 5, 0);
      run_frame(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         load_image(0);
         run_frame(1, 1, 0, 0);
      end
`ifdef CONV_FEEDER_STALL_EN
      load_image(1);
      run_frame(0, 0, 0, 1);
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule
